// File: rtl/chained_shift_unit_if.sv
// Control/data bundle for chained_shift_unit; pause exists only when REG_UNIT_PAUSE_EN is defined.
interface chained_shift_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
);
  logic             ld_a;
  logic             ld_b;
  logic             clr_a;
  logic             shift_en;
  logic             start;
  logic             sign_in;
`ifdef REG_UNIT_PAUSE_EN
  logic             pause;
`endif
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic [CW-1:0]    shift_cnt;

  modport master (
    output ld_a, ld_b, clr_a, shift_en, start, sign_in,
`ifdef REG_UNIT_PAUSE_EN
    output pause,
`endif
    output d,
    input  a, b, a_out, b_out, busy, done, shift_cnt
  );

  modport slave (
    input  ld_a, ld_b, clr_a, shift_en, start, sign_in,
`ifdef REG_UNIT_PAUSE_EN
    input  pause,
`endif
    input  d,
    output a, b, a_out, b_out, busy, done, shift_cnt
  );
endinterface

// File: rtl/chained_shift_unit.sv
// A/B right-shift chain {sign_in -> A -> B} with load/clear, single step and WIDTH-shift burst.
// Optional burst freeze input enabled by defining REG_UNIT_PAUSE_EN.
module chained_shift_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic rst_n,
  chained_shift_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             hold;

  assign a_sh = {bus.sign_in, a_q[WIDTH-1:1]};
  assign b_sh = {a_q[0], b_q[WIDTH-1:1]};

`ifdef REG_UNIT_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // Loads win on their own register; the other one may still single-step.
        if (bus.clr_a) begin
          a_d = '0;
        end else if (bus.ld_a) begin
          a_d = bus.d;
        end else if (bus.shift_en && !bus.start) begin
          a_d = a_sh;
        end
        if (bus.ld_b) begin
          b_d = bus.d;
        end else if (bus.shift_en && !bus.start) begin
          b_d = b_sh;
        end
        if (bus.start) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (!hold) begin
          a_d   = a_sh;
          b_d   = b_sh;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.a_out     = a_q[0];
  assign bus.b_out     = b_q[0];
  assign bus.busy      = (state_q == StShift);
  assign bus.done      = (state_q == StDone);
  assign bus.shift_cnt = cnt_q;

endmodule

// File: tb/tb_chained_shift_unit.sv
// Self-checking bench for chained_shift_unit (WIDTH=8): idle-op vector table plus burst sequences.
module tb_chained_shift_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  typedef struct {
    logic         ld_a;
    logic         ld_b;
    logic         clr_a;
    logic         shift_en;
    logic         sign_in;
    logic [W-1:0] d;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
  } vec_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t exp_q[$];
  vec_t vecs[9];

  chained_shift_unit_if #(.WIDTH(W)) bus ();

  chained_shift_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ld_a     = 1'b0;
    bus.ld_b     = 1'b0;
    bus.clr_a    = 1'b0;
    bus.shift_en = 1'b0;
    bus.start    = 1'b0;
    bus.sign_in  = 1'b0;
    bus.d        = '0;
`ifdef REG_UNIT_PAUSE_EN
    bus.pause    = 1'b0;
`endif
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " a"}, 32'(bus.a), 32'h0);
    check({tag, " b"}, 32'(bus.b), 32'h0);
    check({tag, " busy"}, 32'(bus.busy), 32'h0);
    check({tag, " done"}, 32'(bus.done), 32'h0);
    check({tag, " cnt"}, 32'(bus.shift_cnt), 32'h0);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      total--;
      e = exp_q.pop_front();
      check({tag, " a"}, 32'(bus.a), 32'(e.a));
      check({tag, " b"}, 32'(bus.b), 32'(e.b));
      check({tag, " cnt"}, 32'(bus.shift_cnt), 32'(e.cnt));
    end
  endtask

  // Loads A=81, B=00, then runs one burst with optional ignored-input noise and/or a 2-cycle pause.
  task automatic burst(input string tag, input bit noise, input bit do_pause);
    int busy_cycles;
    int dones;
    int paused;
    bit finished;
    int guard;
    busy_cycles = 0;
    dones       = 0;
    paused      = 0;
    finished    = 1'b0;
    guard       = 0;
    clear_inputs();
    bus.ld_a = 1'b1; bus.d = 8'h81;
    step();
    bus.ld_a = 1'b0; bus.ld_b = 1'b1; bus.d = 8'h00;
    step();
    bus.ld_b = 1'b0; bus.start = 1'b1; bus.sign_in = 1'b0;
    exp_q.push_back('{a: 8'h00, b: 8'h81, cnt: CW'(W)});
    step();
    clear_inputs();
    while (!finished && guard < 40) begin
      guard++;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        dones++;
        pop_compare({tag, " result"});
      end else if (dones > 0) begin
        finished = 1'b1;
        check({tag, " post busy"}, 32'(bus.busy), 32'h0);
      end
      clear_inputs();
      if (noise && bus.busy) begin
        bus.start    = 1'b1;
        bus.shift_en = 1'b1;
        bus.d        = 8'hFF;
        bus.ld_a     = guard[0];
        bus.clr_a    = ~guard[0];
        bus.ld_b     = 1'b1;
      end
`ifdef REG_UNIT_PAUSE_EN
      if (do_pause && bus.busy && bus.shift_cnt == CW'(4) && paused < 2) begin
        bus.pause = 1'b1;
        paused++;
      end
`endif
      if (!finished) step();
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no done pulse expected one within 40 cycles", tag);
    end
    check({tag, " busy cycles"}, 32'(busy_cycles), do_pause ? 32'd10 : 32'd8);
    check({tag, " done pulses"}, 32'(dones), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_inputs();
    //          ld_a  ld_b  clr   sh    sgn   d      exp_a  exp_b
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC5, 8'hC5, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3A, 8'hC5, 8'h3A};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hE2, 8'h9D};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h9D};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 8'h81, 8'h4E};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h5A};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h2D, 8'h2D};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h2D, 8'h2D};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h96, 8'h00};

    #3;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle_zero("post-reset hold");
    end

    for (int i = 0; i < 9; i++) begin
      bus.ld_a     = vecs[i].ld_a;
      bus.ld_b     = vecs[i].ld_b;
      bus.clr_a    = vecs[i].clr_a;
      bus.shift_en = vecs[i].shift_en;
      bus.sign_in  = vecs[i].sign_in;
      bus.d        = vecs[i].d;
      bus.start    = 1'b0;
      exp_q.push_back('{a: vecs[i].exp_a, b: vecs[i].exp_b, cnt: CW'(0)});
      step();
      pop_compare($sformatf("vec%0d", i));
      check($sformatf("vec%0d a_out", i), 32'(bus.a_out), 32'(vecs[i].exp_a[0]));
      check($sformatf("vec%0d b_out", i), 32'(bus.b_out), 32'(vecs[i].exp_b[0]));
      check($sformatf("vec%0d busy", i), 32'(bus.busy), 32'h0);
    end
    clear_inputs();

    burst("burst", 1'b0, 1'b0);

    // Idle single step after a burst leaves the count at WIDTH.
    bus.shift_en = 1'b1;
    exp_q.push_back('{a: 8'h00, b: 8'h40, cnt: CW'(W)});
    step();
    clear_inputs();
    pop_compare("idle step after burst");

    burst("noisy burst", 1'b1, 1'b0);
`ifdef REG_UNIT_PAUSE_EN
    burst("paused burst", 1'b0, 1'b1);
`endif

    // Reset mid-burst after three shifts.
    bus.ld_a = 1'b1; bus.d = 8'h81;
    step();
    clear_inputs();
    bus.start = 1'b1;
    step();
    clear_inputs();
    repeat (3) step();
    check("mid-burst cnt", 32'(bus.shift_cnt), 32'd3);
    check("mid-burst busy", 32'(bus.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("mid-burst reset");
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle_zero("after mid-burst reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
